// File: rtl/tdc_hist_peak_if.sv
// TDC hit stream (timestamp, hit count, last-of-shot) with a valid/ready handshake.
// The master drives the beat; the slave (histogram) returns in_ready.
interface tdc_hist_peak_if;
    logic [14:0] in_data;
    logic [1:0]  in_num;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_num,
        output in_last,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_num,
        input  in_last,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/tdc_hist_peak.sv
// TDC timestamp histogram over a programmed number of shots, followed by a peak-bin scan.
// Optional bin readback port is compiled in when TDC_HIST_READBACK_EN is defined.
module tdc_hist_peak #(
    parameter int unsigned NUM_BINS  = 32,
    parameter int unsigned BIN_AW    = 5,
    parameter int unsigned BIN_SHIFT = 10,
    parameter int unsigned COUNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        shot_target,
    tdc_hist_peak_if.slave     in_if,
    output logic               busy,
    output logic               peak_valid,
    output logic [BIN_AW-1:0]  peak_bin,
    output logic [COUNT_W-1:0] peak_count,
    output logic [15:0]        oor_count,
    output logic               irq,
`ifdef TDC_HIST_READBACK_EN
    input  logic [BIN_AW-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data,
`endif
    input  logic               irq_clr
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAcq,
        StScan,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   bins_q [NUM_BINS];
    logic [COUNT_W-1:0]   bins_d [NUM_BINS];
    logic [15:0]          oor_q, oor_d;
    logic [15:0]          shots_q, shots_d;
    logic [15:0]          target_q, target_d;
    logic [BIN_AW-1:0]    scan_idx_q, scan_idx_d;
    logic [BIN_AW-1:0]    max_bin_q, max_bin_d;
    logic [COUNT_W-1:0]   max_cnt_q, max_cnt_d;
    logic [BIN_AW-1:0]    peak_bin_q, peak_bin_d;
    logic [COUNT_W-1:0]   peak_count_q, peak_count_d;
    logic                 irq_q, irq_d;

    logic [14:0]          hit_shift;
    logic                 hit_in_range;
    logic [BIN_AW-1:0]    hit_idx;
    logic [15:0]          target_eff;

    assign hit_shift    = in_if.in_data >> BIN_SHIFT;
    assign hit_in_range = hit_shift < 15'(NUM_BINS);
    assign hit_idx      = hit_shift[BIN_AW-1:0];
    assign target_eff   = (target_q == 16'd0) ? 16'd1 : target_q;

    always_comb begin
        state_d      = state_q;
        bins_d       = bins_q;
        oor_d        = oor_q;
        shots_d      = shots_q;
        target_d     = target_q;
        scan_idx_d   = scan_idx_q;
        max_bin_d    = max_bin_q;
        max_cnt_d    = max_cnt_q;
        peak_bin_d   = peak_bin_q;
        peak_count_d = peak_count_q;
        irq_d        = irq_q;

        if (irq_clr) begin
            irq_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    target_d = shot_target;
                    state_d  = StClear;
                end
            end
            StClear: begin
                for (int i = 0; i < int'(NUM_BINS); i++) begin
                    bins_d[i] = '0;
                end
                oor_d   = '0;
                shots_d = '0;
                state_d = abort ? StIdle : StAcq;
            end
            StAcq: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (in_if.in_valid) begin
                    // Empty-shot markers (in_num == 0) only count toward shots.
                    if (in_if.in_num != 2'd0) begin
                        if (hit_in_range) begin
                            if (bins_q[hit_idx] != '1) begin
                                bins_d[hit_idx] = bins_q[hit_idx] + 1'b1;
                            end
                        end else if (oor_q != 16'hFFFF) begin
                            oor_d = oor_q + 16'd1;
                        end
                    end
                    if (in_if.in_last) begin
                        shots_d = shots_q + 16'd1;
                        if (shots_d == target_eff) begin
                            state_d    = StScan;
                            scan_idx_d = '0;
                            max_bin_d  = '0;
                            max_cnt_d  = '0;
                        end
                    end
                end
            end
            StScan: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Strict compare keeps the lowest index on ties.
                    if (bins_q[scan_idx_q] > max_cnt_q) begin
                        max_cnt_d = bins_q[scan_idx_q];
                        max_bin_d = scan_idx_q;
                    end
                    if (scan_idx_q == BIN_AW'(NUM_BINS - 1)) begin
                        peak_bin_d   = max_bin_d;
                        peak_count_d = max_cnt_d;
                        state_d      = StDone;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                irq_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            for (int i = 0; i < int'(NUM_BINS); i++) begin
                bins_q[i] <= '0;
            end
            oor_q        <= '0;
            shots_q      <= '0;
            target_q     <= '0;
            scan_idx_q   <= '0;
            max_bin_q    <= '0;
            max_cnt_q    <= '0;
            peak_bin_q   <= '0;
            peak_count_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bins_q       <= bins_d;
            oor_q        <= oor_d;
            shots_q      <= shots_d;
            target_q     <= target_d;
            scan_idx_q   <= scan_idx_d;
            max_bin_q    <= max_bin_d;
            max_cnt_q    <= max_cnt_d;
            peak_bin_q   <= peak_bin_d;
            peak_count_q <= peak_count_d;
            irq_q        <= irq_d;
        end
    end

`ifdef TDC_HIST_READBACK_EN
    logic [COUNT_W-1:0] rd_data_q;

    // Reads the registered bin, so a same-cycle ACQ update is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bins_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`endif

    assign in_if.in_ready = (state_q == StAcq);
    assign busy           = (state_q != StIdle);
    assign peak_valid     = (state_q == StDone);
    assign peak_bin       = peak_bin_q;
    assign peak_count     = peak_count_q;
    assign oor_count      = oor_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_tdc_hist_peak.sv
// Bench for tdc_hist_peak: two instances (default, and BIN_SHIFT=8/COUNT_W=4) driven in lockstep
// and checked against an array-based histogram model.
module tb_tdc_hist_peak;

    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic        rst, start, abort, irq_clr;
    logic [15:0] shot_target;

    tdc_hist_peak_if ifa ();
    tdc_hist_peak_if ifb ();

    logic        busy_a, pv_a, irq_a, busy_b, pv_b, irq_b;
    logic [4:0]  pbin_a, pbin_b;
    logic [11:0] pcnt_a;
    logic [3:0]  pcnt_b;
    logic [15:0] oor_a, oor_b;

    tdc_hist_peak dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .shot_target(shot_target),
        .in_if(ifa.slave), .busy(busy_a), .peak_valid(pv_a), .peak_bin(pbin_a),
        .peak_count(pcnt_a), .oor_count(oor_a), .irq(irq_a), .irq_clr(irq_clr)
    );

    tdc_hist_peak #(.BIN_SHIFT(8), .COUNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .shot_target(shot_target),
        .in_if(ifb.slave), .busy(busy_b), .peak_valid(pv_b), .peak_bin(pbin_b),
        .peak_count(pcnt_b), .oor_count(oor_b), .irq(irq_b), .irq_clr(irq_clr)
    );

    int tests = 0;
    int fails = 0;
    int ha[32];
    int hb[32];
    int oa, ob;
    int last_pb_a, last_pc_a, last_pb_b, last_pc_b;
    bit ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [14:0] d, input logic [1:0] n, input logic l,
                            input logic v);
        ifa.in_data = d; ifa.in_num = n; ifa.in_last = l; ifa.in_valid = v;
        ifb.in_data = d; ifb.in_num = n; ifb.in_last = l; ifb.in_valid = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            ha[i] = 0;
            hb[i] = 0;
        end
        oa = 0;
        ob = 0;
    endtask

    // Reference: bin = timestamp / 2**shift, saturating counters, out-of-range counted apart.
    task automatic model_beat(input int d, input int n);
        int ia, ib;
        if (n == 0) return;
        ia = d / 1024;
        ib = d / 256;
        if (ia < 32) ha[ia] = (ha[ia] < 4095) ? ha[ia] + 1 : 4095;
        else         oa = (oa < 65535) ? oa + 1 : 65535;
        if (ib < 32) hb[ib] = (hb[ib] < 15) ? hb[ib] + 1 : 15;
        else         ob = (ob < 65535) ? ob + 1 : 65535;
    endtask

    task automatic send(input int d, input int n, input logic l);
        bit got;
        got = 1'b0;
        set_beat(15'(d), 2'(n), l, 1'b1);
        for (int k = 0; k < 50; k++) begin
            if (ifa.in_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("beat_accept", {31'd0, got}, 32'd1);
        if (got) begin
            tick();
            model_beat(d, n);
        end
        set_beat(15'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic start_acq(input logic [15:0] tgt);
        shot_target = tgt;
        model_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_busy", {31'd0, busy_a}, 32'd1);
        chk("clear_ready", {31'd0, ifa.in_ready}, 32'd0);
        tick();
    endtask

    // n0 = clock edges already elapsed since (and including) the final accepted last-beat.
    task automatic wait_peak(input string tag, input int n0, input bit clr_at_peak);
        int n, pb, pc;
        n = n0;
        while (!pv_a && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_pv_b"}, {31'd0, pv_b}, 32'd1);
        pb = 0; pc = 0;
        for (int i = 0; i < 32; i++) if (ha[i] > pc) begin pc = ha[i]; pb = i; end
        chk({tag, "_bin_a"}, pbin_a, pb);
        chk({tag, "_cnt_a"}, pcnt_a, pc);
        last_pb_a = pb; last_pc_a = pc;
        pb = 0; pc = 0;
        for (int i = 0; i < 32; i++) if (hb[i] > pc) begin pc = hb[i]; pb = i; end
        chk({tag, "_bin_b"}, pbin_b, pb);
        chk({tag, "_cnt_b"}, pcnt_b, pc);
        last_pb_b = pb; last_pc_b = pc;
        chk({tag, "_oor_a"}, oor_a, oa);
        chk({tag, "_oor_b"}, oor_b, ob);
        irq_clr = clr_at_peak;
        tick();
        irq_clr = 1'b0;
        chk({tag, "_pv_pulse"}, {31'd0, pv_a}, 32'd0);
        chk({tag, "_irq"}, {30'd0, irq_b, irq_a}, 32'd3);
        chk({tag, "_idle"}, {30'd0, busy_b, busy_a}, 32'd0);
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_clr", {30'd0, irq_b, irq_a}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; irq_clr = 1'b0; shot_target = 16'd0;
        set_beat(15'd0, 2'd0, 1'b0, 1'b0);
        model_clear();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_pv", {31'd0, pv_a}, 32'd0);
        chk("rst_irq", {31'd0, irq_a}, 32'd0);
        chk("rst_peak", {pcnt_a, pbin_a}, 32'd0);
        chk("rst_oor", oor_a, 32'd0);
        chk("rst_ready", {31'd0, ifa.in_ready}, 32'd0);

        // in_valid held high while idle is never accepted
        set_beat(15'h0000, 2'd1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_ready", {30'd0, ifb.in_ready, ifa.in_ready}, 32'd0);
        end
        set_beat(15'd0, 2'd0, 1'b0, 1'b0);

        // Single shot, three hits
        start_acq(16'd1);
        send(15'h0400, 1, 1'b0);
        send(15'h0410, 2, 1'b0);
        send(15'h7C00, 1, 1'b1);
        wait_peak("one_shot", 1, 1'b0);
        chk("one_shot_bin", pbin_a, 32'd1);
        clear_irq();

        // Four shots including an empty marker and a discarded empty non-last beat
        start_acq(16'd4);
        send(15'h0800, 1, 1'b1);
        send(15'h0800, 1, 1'b1);
        send(15'h0000, 0, 1'b0);
        send(15'h0000, 0, 1'b1);
        chk("shots3_busy", {31'd0, busy_a}, 32'd1);
        send(15'h0C00, 1, 1'b1);
        wait_peak("four_shot", 1, 1'b0);
        chk("four_shot_cnt", pcnt_a, 32'd2);
        clear_irq();

        // Tie between bins 5 and 9, with irq_clr coincident with peak_valid
        start_acq(16'd1);
        send(15'h1400, 1, 1'b0);
        send(15'h2400, 1, 1'b1);
        wait_peak("tie", 1, 1'b1);
        chk("tie_bin", pbin_a, 32'd5);

        // Top timestamp: bin 31 at default, out of range for the shift-8 instance
        start_acq(16'd1);
        send(15'h7F00, 1, 1'b1);
        wait_peak("oor", 1, 1'b0);
        chk("oor_b_one", oor_b, 32'd1);

        // Empty histogram still produces a result
        start_acq(16'd1);
        send(15'h0000, 0, 1'b1);
        wait_peak("empty", 1, 1'b0);

        // Saturation: 20 hits into bin 0
        start_acq(16'd1);
        for (int k = 0; k < 20; k++) send(15'h0000, 1, (k == 19));
        wait_peak("sat", 1, 1'b0);
        chk("sat_b", pcnt_b, 32'd15);

        // shot_target of 0 behaves as 1
        start_acq(16'd0);
        send(15'h3000, 3, 1'b1);
        wait_peak("tgt0", 1, 1'b0);

        // start and held in_valid during SCAN are ignored
        start_acq(16'd1);
        send(15'h1C00, 1, 1'b1);
        start = 1'b1;
        set_beat(15'h0000, 2'd1, 1'b1, 1'b1);
        tick(); tick(); tick();
        start = 1'b0;
        set_beat(15'd0, 2'd0, 1'b0, 1'b0);
        wait_peak("scan_start", 4, 1'b0);

        // Randomised acquisitions
        for (int r = 0; r < 6; r++) begin
            int tgt, nh;
            tgt = $urandom_range(1, 3);
            start_acq(16'(tgt));
            for (int s = 0; s < tgt; s++) begin
                nh = $urandom_range(0, 5);
                if (nh == 0) send($urandom_range(0, 32767), 0, 1'b1);
                for (int h = 0; h < nh; h++) begin
                    send($urandom_range(0, 32767), $urandom_range(1, 3), (h == nh - 1));
                end
            end
            wait_peak("rand", 1, 1'b0);
        end

        // Abort after 2 of 3 shots: no result, irq and peak outputs untouched
        start_acq(16'd3);
        send(15'h0400, 1, 1'b1);
        send(15'h0400, 1, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {30'd0, busy_b, busy_a}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (pv_a || pv_b) seen++;
            tick();
        end
        chk("abort_no_pv", seen, 32'd0);
        chk("abort_irq", {31'd0, irq_a}, 32'd1);
        chk("abort_bin_a", pbin_a, last_pb_a);
        chk("abort_cnt_a", pcnt_a, last_pc_a);
        chk("abort_bin_b", pbin_b, last_pb_b);
        chk("abort_cnt_b", pcnt_b, last_pc_b);

        // Reset mid-acquisition
        start_acq(16'd2);
        send(15'h7C00, 1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_irq", {30'd0, irq_b, irq_a}, 32'd0);
        chk("mid_rst_peak", {pcnt_a, pbin_a}, 32'd0);
        chk("mid_rst_oor_b", oor_b, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
